// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared board defaults, colour codes, action indices, FSM states
// Rev 1.0  : initial release
// ============================================================================
package game_pkg;

  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;

  localparam logic [2:0] CLR_EMPTY  = 3'b000;
  localparam logic [2:0] CLR_CYAN   = 3'b001;
  localparam logic [2:0] CLR_BLUE   = 3'b010;
  localparam logic [2:0] CLR_ORANGE = 3'b011;
  localparam logic [2:0] CLR_YELLOW = 3'b100;
  localparam logic [2:0] CLR_GREEN  = 3'b101;
  localparam logic [2:0] CLR_PURPLE = 3'b110;
  localparam logic [2:0] CLR_RED    = 3'b111;

  localparam int ACT_RIGHT = 0;
  localparam int ACT_LEFT  = 1;
  localparam int ACT_ROT   = 2;
  localparam int ACT_DROP  = 3;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Frames per gravity tick; evaluated in 10 bits so high levels floor at pmin.
  function automatic logic [9:0] grav_period(input logic [3:0] lvl,
                                             input logic [9:0] base,
                                             input logic [9:0] step,
                                             input logic [9:0] pmin);
    logic [9:0] dec;
    dec = {6'd0, lvl} * step;
    if ((dec < base) && ((base - dec) > pmin)) begin
      return base - dec;
    end
    return pmin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_bank.sv
`default_nettype none
// ============================================================================
// board_bank : COLS*ROWS x CBITS cell store, one write port, registered read
// Rev 1.0    : initial release
// ============================================================================
module board_bank #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int CBITS = 3,
  parameter int AW    = $clog2(COLS * ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [CBITS-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [CBITS-1:0] o_rd_data
);

  localparam int DEPTH = COLS * ROWS;

  logic [CBITS-1:0] r_mem [DEPTH];
  logic [CBITS-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// frame_sequencer : vsync framing, action latching, gravity, double-buffered board
// Rev 1.0         : initial release
// ============================================================================
module frame_sequencer
  import game_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int CBITS     = 3,
  parameter int N_ACT     = 4,
  parameter int FCNT_W    = 11,
  parameter int GRAV_BASE = 48,
  parameter int GRAV_STEP = 4,
  parameter int GRAV_MIN  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic [N_ACT-1:0]          actions,
  input  logic [3:0]                level,
  input  logic                      wr_en,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [CBITS-1:0]          wr_data,
  input  logic                      commit,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [CBITS-1:0]          rd_data,
  output logic                      frame_start,
  output logic [N_ACT-1:0]          act_pulse,
  output logic                      gravity,
  output logic [FCNT_W-1:0]         fcounter,
  output logic [7:0]                drops,
  output logic                      busy,
  output logic                      wr_err
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_busy;
  logic [AW-1:0]     r_clr_addr;
  logic              w_clear_done;

  logic              r_vsync_q;
  logic              w_edge;
  logic              r_frame_start;
  logic [N_ACT-1:0]  r_pend;
  logic [N_ACT-1:0]  r_act_pulse;
  logic [FCNT_W-1:0] r_fcounter;

  logic [9:0]        w_period;
  logic [9:0]        r_grav_cnt;
  logic              r_gravity;

  logic              r_front;
  logic              r_commit_pend;
  logic [7:0]        r_drops;
  logic              r_wr_err;
  logic              w_swap;
  logic              w_drop;
  logic              w_wr_in_range;
  logic              w_wr_ok;
  logic              w_rd_in_range;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [AW-1:0]     w_bank_waddr;
  logic [CBITS-1:0]  w_bank_wdata;
  logic              w_we0;
  logic              w_we1;
  logic [CBITS-1:0]  w_rd0;
  logic [CBITS-1:0]  w_rd1;
  logic              r_rd_ok;
  logic              r_rd_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_addr == AW'(CELLS - 1)) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      CLEAR:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  assign w_clear_done = w_busy && (r_clr_addr == AW'(CELLS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (w_busy) begin
      r_clr_addr <= w_clear_done ? '0 : r_clr_addr + AW'(1);
    end
  end

  // All per-frame registers update on the detected edge so their outputs align with frame_start.
  assign w_edge = vsync & ~r_vsync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vsync_q     <= 1'b0;
      r_frame_start <= 1'b0;
      r_act_pulse   <= '0;
      r_pend        <= '0;
      r_fcounter    <= '0;
    end else begin
      r_vsync_q     <= vsync;
      r_frame_start <= w_edge;
      if (w_edge) begin
        r_act_pulse <= r_pend;
        r_pend      <= actions;
        r_fcounter  <= r_fcounter + FCNT_W'(1);
      end else begin
        r_act_pulse <= '0;
        r_pend      <= r_pend | actions;
      end
    end
  end

  assign w_period = grav_period(level, 10'(GRAV_BASE), 10'(GRAV_STEP), 10'(GRAV_MIN));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grav_cnt <= '0;
      r_gravity  <= 1'b0;
    end else begin
      r_gravity <= 1'b0;
      if (w_clear_done) begin
        r_grav_cnt <= w_period - 10'd1;
      end else if ((r_state == RUN) && w_edge) begin
        if (r_grav_cnt == 10'd0) begin
          r_gravity  <= 1'b1;
          r_grav_cnt <= w_period - 10'd1;
        end else begin
          r_grav_cnt <= r_grav_cnt - 10'd1;
        end
      end
    end
  end

  assign w_swap        = (r_state == RUN) && w_edge && (r_commit_pend || commit);
  assign w_drop        = (r_state == RUN) && w_edge && !(r_commit_pend || commit);
  assign w_wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  assign w_rd_in_range = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
  assign w_wr_ok       = wr_en && (r_state == RUN) && w_wr_in_range && !r_commit_pend;
  assign w_wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign w_rd_addr     = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_front       <= 1'b0;
      r_commit_pend <= 1'b0;
      r_drops       <= '0;
      r_wr_err      <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_rd_sel      <= 1'b0;
    end else begin
      r_wr_err <= wr_en && !w_wr_ok;
      r_rd_ok  <= w_rd_in_range;
      r_rd_sel <= r_front;
      if (w_swap) begin
        r_front       <= ~r_front;
        r_commit_pend <= 1'b0;
      end else if (commit) begin
        r_commit_pend <= 1'b1;
      end
      if (w_drop && (r_drops != 8'hFF)) begin
        r_drops <= r_drops + 8'd1;
      end
    end
  end

  // The sweep owns both write ports; otherwise only the back bank (~front) is writable.
  assign w_we0        = w_busy | (w_wr_ok &  r_front);
  assign w_we1        = w_busy | (w_wr_ok & ~r_front);
  assign w_bank_waddr = w_busy ? r_clr_addr : w_wr_addr;
  assign w_bank_wdata = w_busy ? '0 : wr_data;

  board_bank #(.COLS(COLS), .ROWS(ROWS), .CBITS(CBITS), .AW(AW)) u_bank0 (
    .clk       (clock),
    .rst       (reset),
    .i_wr_en   (w_we0),
    .i_wr_addr (w_bank_waddr),
    .i_wr_data (w_bank_wdata),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd0)
  );

  board_bank #(.COLS(COLS), .ROWS(ROWS), .CBITS(CBITS), .AW(AW)) u_bank1 (
    .clk       (clock),
    .rst       (reset),
    .i_wr_en   (w_we1),
    .i_wr_addr (w_bank_waddr),
    .i_wr_data (w_bank_wdata),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd1)
  );

  assign rd_data     = r_rd_ok ? (r_rd_sel ? w_rd1 : w_rd0) : '0;
  assign frame_start = r_frame_start;
  assign act_pulse   = r_act_pulse;
  assign gravity     = r_gravity;
  assign fcounter    = r_fcounter;
  assign drops       = r_drops;
  assign busy        = w_busy;
  assign wr_err      = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_frame_sequencer : directed stimulus with queued expectations and a monitor
// Rev 1.0            : initial release
// ============================================================================
module tb_frame_sequencer;

  logic        clock;
  logic        reset;
  logic        vsync;
  logic [3:0]  actions;
  logic [3:0]  level;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [4:0]  wr_row;
  logic [2:0]  wr_data;
  logic        commit;
  logic [3:0]  rd_col;
  logic [4:0]  rd_row;
  logic [2:0]  rd_data;
  logic        frame_start;
  logic [3:0]  act_pulse;
  logic        gravity;
  logic [10:0] fcounter;
  logic [7:0]  drops;
  logic        busy;
  logic        wr_err;

  frame_sequencer u_dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .actions     (actions),
    .level       (level),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .commit      (commit),
    .rd_col      (rd_col),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .act_pulse   (act_pulse),
    .gravity     (gravity),
    .fcounter    (fcounter),
    .drops       (drops),
    .busy        (busy),
    .wr_err      (wr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  act;
    logic        grav;
    logic [10:0] fc;
    logic [7:0]  dr;
  } fexp_t;

  fexp_t      fq[$];
  logic [2:0] rq[$];
  logic       wq[$];
  fexp_t      mon_e;
  logic [2:0] mon_r;
  logic       mon_w;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] fc_e   = '0;
  logic [7:0]  drops_e = '0;
  int          k = 0;
  int          per = 48;
  int          n;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic        rd_cap = 1'b0;
  logic        wr_cap = 1'b0;
  logic        fs_q   = 1'b0;

  always @(posedge clock) begin
    rd_cap <= rd_req;
    wr_cap <= wr_req;
  end

  // Monitor: pops the expectation queues whenever the DUT presents a result.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_start) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected fcounter=%0d", fcounter);
        end else begin
          mon_e = fq.pop_front();
          if (act_pulse !== mon_e.act || gravity !== mon_e.grav ||
              fcounter !== mon_e.fc || drops !== mon_e.dr) begin
            errors++;
            $display("FAIL frame got act=%b grav=%b fc=%0d drops=%0d exp act=%b grav=%b fc=%0d drops=%0d",
                     act_pulse, gravity, fcounter, drops, mon_e.act, mon_e.grav, mon_e.fc, mon_e.dr);
          end
        end
        if (fs_q) begin
          checks++;
          errors++;
          $display("FAIL frame_width got=2+ cycles exp=1 cycle");
        end
      end else if (act_pulse !== 4'b0 || gravity !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL idle_pulse got act=%b grav=%b exp act=0000 grav=0", act_pulse, gravity);
      end
      if (rd_cap) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected rd_data=%b", rd_data);
        end else begin
          mon_r = rq.pop_front();
          if (rd_data !== mon_r) begin
            errors++;
            $display("FAIL read got=%b exp=%b", rd_data, mon_r);
          end
        end
      end
      if (wr_cap) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected wr_err=%b", wr_err);
        end else begin
          mon_w = wq.pop_front();
          if (wr_err !== mon_w) begin
            errors++;
            $display("FAIL wr_err got=%b exp=%b", wr_err, mon_w);
          end
        end
      end
    end
    fs_q = frame_start;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic frame(input logic [3:0] act_in, input logic cmt, input logic [3:0] act_e,
                       input logic grav_e, input logic [7:0] dr_e);
    fc_e++;
    fq.push_back('{act: act_e, grav: grav_e, fc: fc_e, dr: dr_e});
    vsync   = 1'b1;
    actions = act_in;
    commit  = cmt;
    @(negedge clock);
    vsync   = 1'b0;
    actions = '0;
    commit  = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Frame after leaving CLEAR: gravity every per-th frame, drops unless this frame swaps.
  task automatic run_frame(input logic [3:0] act_in, input logic cmt, input logic [3:0] act_e,
                           input logic swap);
    k++;
    if (!swap && drops_e != 8'd255) drops_e++;
    frame(act_in, cmt, act_e, (k % per) == 0, drops_e);
  endtask

  task automatic rd(input int c, input int r, input logic [2:0] e);
    rd_col = 4'(c);
    rd_row = 5'(r);
    rq.push_back(e);
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
  endtask

  task automatic wr(input int c, input int r, input logic [2:0] d, input logic err_e);
    wr_col  = 4'(c);
    wr_row  = 5'(r);
    wr_data = d;
    wr_en   = 1'b1;
    wq.push_back(err_e);
    wr_req  = 1'b1;
    @(negedge clock);
    wr_en   = 1'b0;
    wr_req  = 1'b0;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
  endtask

  task automatic do_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    fc_e  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic busy_count(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; actions = '0; level = 4'd0;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0; commit = 1'b0;
    rd_col = '0; rd_row = '0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {rd_data, frame_start, act_pulse, gravity, fcounter, drops, wr_err}, 64'd0);
    reset = 1'b0;

    // T1: post-reset clear sweep
    busy_count(n);
    chk("busy_cycles", n, 200);
    chk("fcounter_after_clear", fcounter, 0);
    rd(0, 0, 3'b000);
    rd(9, 19, 3'b000);
    rd(3, 7, 3'b000);
    rd(10, 0, 3'b000);
    rd(0, 20, 3'b000);
    @(negedge clock);

    // T2: five frames, no commits
    for (int i = 0; i < 5; i++) run_frame(4'b0, 1'b0, 4'b0, 1'b0);
    chk("fcounter_5", fcounter, 5);

    // T3: actions mid-frame, then an action coincident with the edge
    actions = 4'b0001;
    repeat (3) @(negedge clock);
    actions = 4'b0000;
    run_frame(4'b0000, 1'b0, 4'b0001, 1'b0);
    run_frame(4'b0000, 1'b0, 4'b0000, 1'b0);
    run_frame(4'b0010, 1'b0, 4'b0000, 1'b0);
    run_frame(4'b0000, 1'b0, 4'b0010, 1'b0);

    // T5: write, commit, frozen back bank, out-of-range column
    wr(3, 7, 3'b101, 1'b0);
    commit_pulse();
    wr(3, 7, 3'b111, 1'b1);
    run_frame(4'b0, 1'b0, 4'b0, 1'b1);
    rd(3, 7, 3'b101);
    wr(10, 0, 3'b001, 1'b1);
    wr(3, 7, 3'b010, 1'b0);
    rd(3, 7, 3'b101);

    // T6: frames without commit keep the front; commit on the edge swaps at once
    for (int i = 0; i < 3; i++) run_frame(4'b0, 1'b0, 4'b0, 1'b0);
    rd(3, 7, 3'b101);
    run_frame(4'b0, 1'b1, 4'b0, 1'b1);
    rd(3, 7, 3'b010);
    rd(1, 1, 3'b000);

    // T4 (level 0): ticks every 48th frame; also runs drops into saturation
    while (k < 260) run_frame(4'b0, 1'b0, 4'b0, 1'b0);
    chk("drops_saturated", drops, 255);

    // Reset mid-CLEAR: writes rejected, frames still counted, sweep restarts
    level = 4'd15;
    do_reset();
    repeat (20) @(negedge clock);
    chk("busy_mid_clear", busy, 1);
    wr(0, 0, 3'b011, 1'b1);
    frame(4'b0, 1'b0, 4'b0, 1'b0, 8'd0);
    do_reset();
    busy_count(n);
    chk("busy_restart_cycles", n, 200);

    // T4 variant (level 15): period floors at 2
    k = 0;
    drops_e = '0;
    per = 2;
    for (int i = 0; i < 6; i++) run_frame(4'b0, 1'b0, 4'b0, 1'b0);
    rd(3, 7, 3'b000);
    rd(5, 5, 3'b000);

    repeat (3) @(negedge clock);
    chk("frames_outstanding", fq.size(), 0);
    chk("reads_outstanding", rq.size(), 0);
    chk("writes_outstanding", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
